// File: rtl/keypad_pkg.sv
// Shared types and sizing helpers for the matrix keypad scanner.
package keypad_pkg;

   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 4;

   function automatic int key_w(input int rows, input int cols);
      return (rows * cols > 1) ? $clog2(rows * cols) : 1;
   endfunction

   localparam int DEF_KW = key_w(DEF_ROWS, DEF_COLS);

   // Candidate encoding is KW+1 bits; MSB set means no key pressed.
   localparam logic [DEF_KW:0] NO_KEY = {1'b1, {DEF_KW{1'b0}}};

   typedef enum logic {IDLE, HELD} state_t;

endpackage

// File: rtl/keypad_debounce.sv
// Scan-to-scan debounce and commit state machine producing press/release strobes.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int KW             = DEF_KW,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [KW:0]   cand,
   input  logic          scan_done,
   output logic [KW-1:0] key_code,
   output logic          key_held,
   output logic          key_valid,
   output logic          key_release
);

   localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [KW:0] NONE = {1'b1, {KW{1'b0}}};

   state_t        state;
   logic [KW:0]   prev;
   logic [SW-1:0] stable_cnt;
   logic [SW-1:0] cnt_next;
   logic [KW:0]   committed;
   logic          commit;

   always_comb begin
      cnt_next = SW'(1);
      if (cand == prev)
         cnt_next = (stable_cnt == SW'(DEBOUNCE_SCANS)) ? stable_cnt : stable_cnt + SW'(1);
      committed = (state == HELD) ? {1'b0, key_code} : NONE;
      commit    = scan_done && (cnt_next == SW'(DEBOUNCE_SCANS)) && (cand != committed);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         prev        <= NONE;
         stable_cnt  <= '0;
         key_code    <= '0;
         key_held    <= 1'b0;
         key_valid   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_valid   <= 1'b0;
         key_release <= 1'b0;
         if (scan_done) begin
            prev       <= cand;
            stable_cnt <= cnt_next;
         end
         if (commit) begin
            case (state)
               IDLE: begin
                  state     <= HELD;
                  key_code  <= cand[KW-1:0];
                  key_held  <= 1'b1;
                  key_valid <= 1'b1;
               end
               HELD: begin
                  key_release <= 1'b1;
                  if (cand[KW]) begin
                     state    <= IDLE;
                     key_held <= 1'b0;
                  end else begin
                     // direct key-to-key change: release old and press new together
                     key_valid <= 1'b1;
                     key_code  <= cand[KW-1:0];
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Row-driving keypad scanner: column synchronizer, dwell/row counters and
// lowest-index candidate encoder feeding the debounce stage.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS           = DEF_ROWS,
   parameter int COLS           = DEF_COLS,
   parameter int SCAN_PERIOD    = 200000,
   parameter int DEBOUNCE_SCANS = 3,
   localparam int KW            = key_w(ROWS, COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [COLS-1:0] col_in,
   output logic [ROWS-1:0] row_out,
   output logic [KW-1:0]   key_code,
   output logic            key_held,
   output logic            key_valid,
   output logic            key_release
);

   localparam int DW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam logic [KW:0] NONE = {1'b1, {KW{1'b0}}};

   logic [COLS-1:0] sync1, sync2;
   logic [DW-1:0]   dwell;
   logic [RW-1:0]   row;
   logic [KW:0]     acc, cand, base, next_acc;
   logic            scan_done;
   logic            last_dwell;
   logic            hit;
   logic [CW-1:0]   col_idx;
   logic [KW-1:0]   row_key;

   assign last_dwell = (dwell == DW'(SCAN_PERIOD - 1));

   // Lowest pressed column in the current row (columns are active-low).
   always_comb begin
      hit     = 1'b0;
      col_idx = '0;
      for (int c = COLS - 1; c >= 0; c--) begin
         if (!sync2[c]) begin
            hit     = 1'b1;
            col_idx = CW'(c);
         end
      end
      row_key  = KW'(row) * KW'(COLS) + KW'(col_idx);
      base     = (row == '0) ? NONE : acc;
      next_acc = (base[KW] && hit) ? {1'b0, row_key} : base;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1     <= '1;
         sync2     <= '1;
         dwell     <= '0;
         row       <= '0;
         row_out   <= ~ROWS'(1);
         acc       <= NONE;
         cand      <= NONE;
         scan_done <= 1'b0;
      end else begin
         sync1     <= col_in;
         sync2     <= sync1;
         scan_done <= 1'b0;
         if (last_dwell) begin
            dwell <= '0;
            acc   <= next_acc;
            if (row == RW'(ROWS - 1)) begin
               row       <= '0;
               row_out   <= ~ROWS'(1);
               cand      <= next_acc;
               scan_done <= 1'b1;
            end else begin
               row     <= row + RW'(1);
               row_out <= ~(ROWS'(1) << (row + RW'(1)));
            end
         end else begin
            dwell <= dwell + DW'(1);
         end
      end
   end

   keypad_debounce #(
      .KW             (KW),
      .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
   ) u_debounce (
      .clk         (clk),
      .rst         (rst),
      .cand        (cand),
      .scan_done   (scan_done),
      .key_code    (key_code),
      .key_held    (key_held),
      .key_valid   (key_valid),
      .key_release (key_release)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: 4x4 matrix, 4-cycle dwell, 3-scan debounce.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  col_in;
   logic [3:0]  row_out;
   logic [3:0]  key_code;
   logic        key_held, key_valid, key_release;
   logic [15:0] pressed = '0;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      logic       v;
      logic       r;
      logic [3:0] code;
      logic       held;
      int         cycle;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   // Keypad model: a pressed key pulls its column low while its row is driven.
   always_comb begin
      col_in = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!row_out[r] && pressed[r*4+c]) col_in[c] = 1'b0;
   end

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   keypad_scanner #(
      .ROWS           (4),
      .COLS           (4),
      .SCAN_PERIOD    (4),
      .DEBOUNCE_SCANS (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .col_in      (col_in),
      .row_out     (row_out),
      .key_code    (key_code),
      .key_held    (key_held),
      .key_valid   (key_valid),
      .key_release (key_release)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every strobe must match the head of the expectation queue.
   always @(negedge clk) begin
      if (!rst && (key_valid === 1'b1 || key_release === 1'b1)) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_pulse: got v=%b r=%b code=%0d at cyc %0d, want no pulse",
                     key_valid, key_release, key_code, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_fields", {26'd0, key_valid, key_release, key_code},
                  {26'd0, e.v, e.r, e.code});
            check("pulse_held", 32'(key_held), 32'(e.held));
            check("pulse_cycle", cyc, e.cycle);
         end
      end
   end

   task automatic do_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      check("rst_row_out", 32'(row_out), 32'h0000000E);
      check("rst_key_code", 32'(key_code), 32'd0);
      check("rst_key_held", 32'(key_held), 32'd0);
      check("rst_key_valid", 32'(key_valid), 32'd0);
      check("rst_key_release", 32'(key_release), 32'd0);
      rst = 1'b0;
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic push(input logic v, input logic r, input logic [3:0] code,
                       input logic held, input int cycle);
      exp_t e;
      e.v = v; e.r = r; e.code = code; e.held = held; e.cycle = cycle;
      q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] er;

      // Idle: rows walk E,D,B,7 every 4 cycles, no strobes.
      pressed = '0;
      do_reset(2);
      repeat (200) begin
         @(negedge clk);
         er = ~(4'b0001 << ((cyc / 4) % 4));
         check("idle_row_out", 32'(row_out), 32'(er));
      end
      check("idle_key_held", 32'(key_held), 32'd0);

      // Key 6 held from reset, then released mid-scan.
      pressed = 16'h0040;
      do_reset(2);
      push(1'b1, 1'b0, 4'd6, 1'b1, 49);
      wait_cyc(60);
      pressed = '0;
      push(1'b0, 1'b1, 4'd6, 1'b0, 113);
      wait_cyc(130);
      check("k6_drained", q.size(), 0);
      check("k6_code_kept", 32'(key_code), 32'd6);
      check("k6_held_low", 32'(key_held), 32'd0);

      // Keys 6 and 9: lowest wins, then a direct change to 9.
      pressed = 16'h0240;
      do_reset(2);
      push(1'b1, 1'b0, 4'd6, 1'b1, 49);
      wait_cyc(60);
      pressed = 16'h0200;
      push(1'b1, 1'b1, 4'd9, 1'b1, 113);
      wait_cyc(130);
      check("k69_drained", q.size(), 0);
      check("k69_code", 32'(key_code), 32'd9);
      check("k69_held", 32'(key_held), 32'd1);

      // Key 12 bouncing every scan: nothing commits.
      pressed = 16'h1000;
      do_reset(2);
      while (cyc < 160) begin
         @(negedge clk);
         if (cyc % 16 == 0) pressed[12] = ~pressed[12];
      end
      wait_cyc(170);
      check("bounce_held", 32'(key_held), 32'd0);
      check("bounce_drained", q.size(), 0);

      // Key 3: reset while held, then recommit.
      pressed = 16'h0008;
      do_reset(2);
      push(1'b1, 1'b0, 4'd3, 1'b1, 49);
      wait_cyc(60);
      check("k3_held", 32'(key_held), 32'd1);
      do_reset(1);
      push(1'b1, 1'b0, 4'd3, 1'b1, 49);
      wait_cyc(70);
      check("k3_drained", q.size(), 0);

      // Key 15 held for 20 scans: exactly one press strobe.
      pressed = 16'h8000;
      do_reset(2);
      push(1'b1, 1'b0, 4'd15, 1'b1, 49);
      wait_cyc(330);
      check("k15_drained", q.size(), 0);
      check("k15_code", 32'(key_code), 32'd15);
      check("k15_held", 32'(key_held), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
